fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a small queue, and redirect flush with stale-response discard.
module fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_npc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {RESET_WAIT, RUN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   disc_q, disc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic accept, rsp, push, pop;

  assign accept = imem_req & imem_gnt;
  // Responses with nothing in flight (e.g. left over from before a reset) are ignored.
  assign rsp    = imem_rvalid && (inflight_q != '0);
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_WAIT: state_d = RUN;
      RUN:        if (halt && inflight_q == '0) state_d = HALTED;
      HALTED:     if (!halt) state_d = RUN;
      default:    state_d = RESET_WAIT;
    endcase
  end

  // In-flight requests include those already marked for discard, so a flush never
  // frees credit that a stale response will still consume.
  always_comb begin
    imem_req  = (state_q == RUN) && !halt &&
                (({1'b0, cnt_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH));
    imem_addr = pc_q;
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    cnt_d      = cnt_q;
    disc_d     = disc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push       = 1'b0;
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp);

    if (redir_valid) begin
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      disc_d   = inflight_d;
    end else begin
      if (accept) pc_d = pc_q + INC;
      if (rsp) begin
        if (disc_q != '0) disc_d = disc_q - CNT_W'(1);
        else              push   = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rsp_pc_d = rsp_pc_q + INC;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      cnt_q      <= '0;
      inflight_q <= '0;
      disc_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      disc_q     <= disc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: queue storage has no reset; it is only read through out_valid-gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  always_comb begin
    out_valid = (cnt_q != '0);
    out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
    out_npc   = out_valid ? (pc_mem[rd_ptr_q] + INC) : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order memory model whose responses can be
// held off, and a scoreboard monitor that checks every entry decode accepts.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, halt, redir_valid, imem_gnt, out_ready;
  logic [15:0] redir_pc;
  logic        imem_req, imem_rvalid, out_valid;
  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc, out_npc;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pend[$];
  int          errors = 0;
  int          checks = 0;
  int          grants = 0;
  bit          hold = 1'b0;
  bit          stray = 1'b0;
  logic        mm_acc, mm_rv;
  logic [15:0] mm_addr;
  int          g;

  fetch_queue dut (
    .clk(clk), .rst(rst), .halt(halt), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_npc(out_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [15:0] npc);
    exp_t e;
    e.pc = pc; e.npc = npc; e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_grants(input int target, input string name);
    for (int i = 0; i < 200 && grants < target; i++) @(negedge clk);
    if (grants < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, grants %0d expected %0d", name, grants, target);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: timeout, %0d entries never delivered", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory model: samples the request side mid-cycle, answers in order one per cycle.
  always begin
    @(negedge clk);
    #2;
    mm_acc  = imem_req & imem_gnt;
    mm_addr = imem_addr;
    mm_rv   = imem_rvalid;
    @(posedge clk);
    #1;
    if (!rst) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (mm_rv && pend.size() > 0) void'(pend.pop_front());
      if (mm_acc) begin
        pend.push_back(mm_addr);
        grants++;
      end
      if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
      end else if (!hold && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend[0]);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Scoreboard monitor: every accepted head entry must match the next expectation.
  always begin
    @(negedge clk);
    #1;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", 32'(out_pc), 32'(e.pc));
        check("out_npc", 32'(out_npc), 32'(e.npc));
        check("out_instr", 32'(out_instr), 32'(e.instr));
      end
    end
  end

  initial begin
    rst = 1'b1; halt = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    imem_gnt = 1'b0; out_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    repeat (2) @(negedge clk);

    // Sequential fetch with immediate consumption.
    rst = 1'b1; imem_gnt = 1'b1; out_ready = 1'b1;
    push_exp(16'h0000, 16'h0002); push_exp(16'h0002, 16'h0004);
    push_exp(16'h0004, 16'h0006); push_exp(16'h0006, 16'h0008);
    push_exp(16'h0008, 16'h000A); push_exp(16'h000A, 16'h000C);
    @(negedge clk); #1;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", 32'(imem_addr), 32'h0000);
    wait_grants(6, "seq_grants");
    imem_gnt = 1'b0;
    wait_drain("seq_drain");

    // Back-pressure fills the queue to DEPTH, then drains in order and refetches.
    out_ready = 1'b0; imem_gnt = 1'b1; g = grants;
    repeat (10) @(negedge clk);
    #1;
    check("full_grants", 32'(grants - g), 4);
    check("full_no_req", 32'(imem_req), 0);
    check("full_valid", 32'(out_valid), 1);
    check("full_head_pc", 32'(out_pc), 32'h000C);
    check("full_head_npc", 32'(out_npc), 32'h000E);
    check("full_head_instr", 32'(out_instr), 32'(16'h000C ^ 16'h5A5A));
    @(negedge clk);
    push_exp(16'h000C, 16'h000E); push_exp(16'h000E, 16'h0010);
    push_exp(16'h0010, 16'h0012); push_exp(16'h0012, 16'h0014);
    push_exp(16'h0014, 16'h0016); push_exp(16'h0016, 16'h0018);
    out_ready = 1'b1;
    wait_grants(g + 6, "refill_grants");
    imem_gnt = 1'b0;
    wait_drain("refill_drain");
    #1 check("after_refill_addr", 32'(imem_addr), 32'h0018);

    // Redirect with two responses outstanding, one arriving in the redirect cycle.
    @(negedge clk);
    hold = 1'b1; imem_gnt = 1'b1; g = grants;
    wait_grants(g + 2, "redir_grants");
    imem_gnt = 1'b0;
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    redir_valid = 1'b1; redir_pc = 16'h0100;
    @(negedge clk);
    redir_valid = 1'b0; imem_gnt = 1'b1; g = grants;
    push_exp(16'h0100, 16'h0102); push_exp(16'h0102, 16'h0104);
    #1;
    check("redir_addr", 32'(imem_addr), 32'h0100);
    check("redir_flush_valid", 32'(out_valid), 0);
    wait_grants(g + 2, "redir_new_grants");
    imem_gnt = 1'b0;
    wait_drain("redir_drain");

    // PC wrap at the top of the address space.
    @(negedge clk);
    redir_valid = 1'b1; redir_pc = 16'hFFFE;
    @(negedge clk);
    redir_valid = 1'b0; imem_gnt = 1'b1; g = grants;
    push_exp(16'hFFFE, 16'h0000); push_exp(16'h0000, 16'h0002);
    wait_grants(g + 2, "wrap_grants");
    imem_gnt = 1'b0;
    wait_drain("wrap_drain");
    #1 check("wrap_next_addr", 32'(imem_addr), 32'h0002);

    // Halt with one response outstanding, drain, then resume sequentially.
    @(negedge clk);
    hold = 1'b1; imem_gnt = 1'b1; g = grants;
    wait_grants(g + 1, "halt_grant");
    imem_gnt = 1'b0; halt = 1'b1;
    #1 check("halt_no_req", 32'(imem_req), 0);
    repeat (3) @(negedge clk);
    #1 check("halt_still_no_req", 32'(imem_req), 0);
    @(negedge clk);
    hold = 1'b0;
    push_exp(16'h0002, 16'h0004);
    wait_drain("halt_drain");
    imem_gnt = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("halted_grants", 32'(grants - g), 1);
    check("halted_no_req", 32'(imem_req), 0);
    @(negedge clk);
    halt = 1'b0;
    push_exp(16'h0004, 16'h0006);
    wait_grants(g + 2, "resume_grant");
    imem_gnt = 1'b0;
    wait_drain("resume_drain");
    #1 check("resume_addr", 32'(imem_addr), 32'h0006);

    // Grant stall with a queued entry, then asynchronous reset mid-stall.
    @(negedge clk);
    out_ready = 1'b0; imem_gnt = 1'b1; g = grants;
    wait_grants(g + 1, "stall_grant");
    imem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stall_valid", 32'(out_valid), 1);
    check("stall_head_pc", 32'(out_pc), 32'h0006);
    check("stall_req", 32'(imem_req), 1);
    check("stall_addr0", 32'(imem_addr), 32'h0008);
    @(negedge clk); #1 check("stall_addr1", 32'(imem_addr), 32'h0008);
    @(negedge clk); #1 check("stall_addr2", 32'(imem_addr), 32'h0008);
    #3 rst = 1'b0;
    #1;
    check("arst_imem_req", 32'(imem_req), 0);
    check("arst_imem_addr", 32'(imem_addr), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_instr", 32'(out_instr), 0);
    check("arst_out_pc", 32'(out_pc), 0);
    check("arst_out_npc", 32'(out_npc), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stray_ignored", 32'(out_valid), 0);
    check("post_rst_req", 32'(imem_req), 1);
    check("post_rst_addr", 32'(imem_addr), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
